// File: rtl/rst_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rst_seq_pkg
//  Brief    : Shared types and elaboration helpers for the reset sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package rst_seq_pkg;

    // Sequencer phases: initial hold, inter-domain steps, all released
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } rst_seq_state_e;

    function automatic int rst_seq_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Timer must be able to hold the larger of the two schedule lengths
    function automatic int rst_seq_cnt_w(input int hold, input int step);
        return $clog2(rst_seq_max(hold, step) + 1);
    endfunction

    // Domain index width, never narrower than one bit
    function automatic int rst_seq_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit rst_seq_params_ok(input int n, input int hold, input int step);
        return (n >= 1) && (hold >= 1) && (step >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq_timer.sv
`default_nettype none
// ============================================================================
//  Module   : rst_seq_timer
//  Brief    : Saturating up-counter with synchronous clear and a terminal-count
//             flag raised when the count equals the supplied limit.
//  Revision : 1.0  initial release
// ============================================================================
module rst_seq_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count: the release is due on the edge that sees this high
    assign tc_o = (cnt_q == limit_i);

    // Next count: clear wins, otherwise advance and stop at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register, cleared asynchronously with the incoming reset
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rst_sequencer
//  Brief    : Releases NUM_OUTS active-low reset domains one at a time in a
//             fixed order on a HOLD/STEP cycle schedule, flags Ready when all
//             are out of reset, and restarts on a software reset request.
//  Revision : 1.0  initial release
// ============================================================================
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_OUTS    = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8
) (
    input  logic                clk,
    input  logic                RST,
    input  logic                SW_RST_REQ,
    output logic [NUM_OUTS-1:0] Seq_RST,
    output logic                Ready
);

    localparam int  CNT_W     = rst_seq_cnt_w(HOLD_CYCLES, STEP_CYCLES);
    localparam int  IDX_W     = rst_seq_idx_w(NUM_OUTS);
    localparam bit  PARAMS_OK = rst_seq_params_ok(NUM_OUTS, HOLD_CYCLES, STEP_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_OUTS - 1);
    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LIMIT = CNT_W'(STEP_CYCLES - 1);

    if (!PARAMS_OK) begin : g_param_check
        $error("rst_sequencer: NUM_OUTS, HOLD_CYCLES and STEP_CYCLES must all be >= 1");
    end

    rst_seq_state_e      state_q;
    logic [IDX_W-1:0]    index_q;
    logic [NUM_OUTS-1:0] seq_rst_q;
    logic                ready_q;

    logic                w_tc;
    logic                w_release;
    logic                w_timer_clr;
    logic                w_timer_en;
    logic [CNT_W-1:0]    w_limit;

    // A release is due whenever the timer reaches the current phase length
    assign w_release   = w_tc && (state_q != DONE);
    // The timer restarts after every release and on every software request
    assign w_timer_clr = SW_RST_REQ || w_release;
    assign w_timer_en  = (state_q != DONE);
    assign w_limit     = (state_q == HOLD) ? HOLD_LIMIT : STEP_LIMIT;

    rst_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .RST     (RST),
        .clr_i   (w_timer_clr),
        .en_i    (w_timer_en),
        .limit_i (w_limit),
        .tc_o    (w_tc)
    );

    // Sequencer FSM: software request restarts from HOLD, releases set one
    // bit at a time in index order so the outputs stay thermometer-coded
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q   <= HOLD;
            index_q   <= '0;
            seq_rst_q <= '0;
            ready_q   <= 1'b0;
        end else if (SW_RST_REQ) begin
            state_q   <= HOLD;
            index_q   <= '0;
            seq_rst_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                HOLD, STEP: begin
                    if (w_tc) begin
                        seq_rst_q[index_q] <= 1'b1;
                        if (index_q == LAST_IDX) begin
                            state_q <= DONE;
                        end else begin
                            index_q <= index_q + IDX_W'(1);
                            state_q <= STEP;
                        end
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= HOLD;
                end
            endcase
        end
    end

    assign Seq_RST = seq_rst_q;
    assign Ready   = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rst_sequencer
//  Brief    : Self-checking bench for rst_sequencer; a three-domain instance
//             and a single-domain instance share clock, reset and request.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rst_sequencer;

    localparam int N  = 3;
    localparam int H  = 4;
    localparam int S  = 2;
    localparam int N1 = 1;
    localparam int H1 = 1;
    localparam int S1 = 3;

    logic          clk = 1'b0;
    logic          RST;
    logic          SW_RST_REQ;
    logic [N-1:0]  seq;
    logic          rdy;
    logic [N1-1:0] seq1;
    logic          rdy1;

    int total = 0;
    int bad   = 0;
    // Edges seen since the sequence last (re)started
    int ev    = 0;

    always #5 clk = ~clk;

    rst_sequencer #(
        .NUM_OUTS    (N),
        .HOLD_CYCLES (H),
        .STEP_CYCLES (S)
    ) u_dut (
        .clk        (clk),
        .RST        (RST),
        .SW_RST_REQ (SW_RST_REQ),
        .Seq_RST    (seq),
        .Ready      (rdy)
    );

    rst_sequencer #(
        .NUM_OUTS    (N1),
        .HOLD_CYCLES (H1),
        .STEP_CYCLES (S1)
    ) u_dut1 (
        .clk        (clk),
        .RST        (RST),
        .SW_RST_REQ (SW_RST_REQ),
        .Seq_RST    (seq1),
        .Ready      (rdy1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d, t=%0t)", tag, got, exp, ev, $time);
        end
    endtask

    // Bit k is out of reset once HOLD + k*STEP edges have elapsed
    function automatic logic [31:0] exp_seq(input int e, input int n, input int h, input int s);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) begin
            if (e >= h + k * s) r[k] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_rdy(input int e, input int n, input int h, input int s);
        return (e >= h + (n - 1) * s + 1) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] is_thermo(input logic [31:0] v);
        return ((v & (v + 32'd1)) == 32'd0) ? 32'd1 : 32'd0;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".seq"},    32'(seq),  exp_seq(ev, N, H, S));
        chk({tag, ".rdy"},    32'(rdy),  exp_rdy(ev, N, H, S));
        chk({tag, ".therm"},  is_thermo(32'(seq)), 32'd1);
        chk({tag, ".seq1"},   32'(seq1), exp_seq(ev, N1, H1, S1));
        chk({tag, ".rdy1"},   32'(rdy1), exp_rdy(ev, N1, H1, S1));
    endtask

    function automatic void model_edge(input logic r, input logic q);
        if (!r || q) ev = 0;
        else if (ev < 100000) ev++;
    endfunction

    // One clock: drive at the falling edge, model the rising edge, check at the next fall
    task automatic cycle(input logic r, input logic q, input string tag);
        RST        = r;
        SW_RST_REQ = q;
        @(posedge clk);
        model_edge(r, q);
        @(negedge clk);
        check_all(tag);
    endtask

    // Assert the reset asynchronously shortly after a rising edge
    task automatic async_rst(input string tag);
        @(posedge clk);
        model_edge(RST, SW_RST_REQ);
        #1;
        check_all({tag, ".pre"});
        #1;
        RST = 1'b0;
        ev  = 0;
        #1;
        check_all({tag, ".now"});
        @(negedge clk);
        check_all({tag, ".fall"});
    endtask

    initial begin
        RST        = 1'b1;
        SW_RST_REQ = 1'b0;
        #1;
        RST = 1'b0;
        #1;
        check_all("t1.pre_clk");
        @(negedge clk);
        check_all("t1.first");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "t1");

        // Full release schedule from reset deassertion
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, "t2");
            if (i == 3) chk("t2.edge4", 32'(seq), 32'b001);
            if (i == 5) chk("t2.edge6", 32'(seq), 32'b011);
            if (i == 7) chk("t2.edge8_rdy", 32'(rdy), 32'd0);
            if (i == 8) chk("t2.edge9_rdy", 32'(rdy), 32'd1);
        end

        // Asynchronous reset between edges 5 and 6, then a fresh schedule
        cycle(1'b0, 1'b0, "t3.rst");
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, "t3.run");
        async_rst("t3.async");
        chk("t3.async_seq", 32'(seq), 32'd0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, "t3.hold");
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, "t3.rerun");

        // Software request while fully released
        cycle(1'b1, 1'b1, "t4.req");
        chk("t4.req_rdy", 32'(rdy), 32'd0);
        cycle(1'b1, 1'b1, "t4.req");
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, "t4.run");
            if (i == 2) chk("t4.edge3", 32'(seq), 32'd0);
            if (i == 3) chk("t4.edge4", 32'(seq), 32'b001);
        end

        // Software request coinciding with the second release
        cycle(1'b1, 1'b1, "t5.clr");
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, "t5.run");
        cycle(1'b1, 1'b1, "t5.edge6");
        chk("t5.edge6_seq", 32'(seq), 32'd0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, "t5.rerun");

        // Randomized mix of resets, requests and long quiet stretches
        for (int i = 0; i < 800; i++) begin
            logic r;
            logic q;
            r = ($urandom_range(0, 39) != 0);
            q = ($urandom_range(0, 14) == 0);
            if (RST && $urandom_range(0, 59) == 0) begin
                async_rst("rnd.async");
            end else begin
                cycle(r, q, "rnd");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
